// File: rtl/afu_copy_mo.sv
// Line-copy AFU: reads num_clines lines from src_base and writes them to dst_base with up to
// MAX_OUT lines in flight. Define AFU_COPY_MO_CHECKSUM_EN to build the read-data XOR checksum.
module afu_copy_mo #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int MAX_OUT     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_LMT-1:0]    rd_req_addr,
  output logic [MDATA-1:0]       rd_req_mdata,
  output logic                   rd_req_en,
  input  logic                   rd_req_almostfull,
  input  logic                   rd_rsp_valid,
  input  logic [MDATA-1:0]       rd_rsp_mdata,
  input  logic [CACHE_WIDTH-1:0] rd_rsp_data,
  output logic [ADDR_LMT-1:0]    wr_req_addr,
  output logic [MDATA-1:0]       wr_req_mdata,
  output logic [CACHE_WIDTH-1:0] wr_req_data,
  output logic                   wr_req_en,
  input  logic                   wr_req_almostfull,
  input  logic                   wr_rsp0_valid,
  input  logic                   wr_rsp1_valid,
  input  logic [MDATA-1:0]       wr_rsp0_mdata,
  input  logic [MDATA-1:0]       wr_rsp1_mdata,
  input  logic                   start,
  output logic                   done,
  input  logic [511:0]           afu_context,
  output logic [31:0]            checksum
);

  // Handshake: a request transfers in every cycle its _en is high, and _en is only raised while
  // the matching _almostfull is low. Responses are one-cycle strobes that cannot be stalled.

  localparam int SLOT_W = $clog2(MAX_OUT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            num_q, num_d;
  logic [31:0]            rd_issued_q, rd_issued_d;
  logic [31:0]            wr_done_q, wr_done_d;
  logic [ADDR_LMT-1:0]    src_q, src_d;
  logic [ADDR_LMT-1:0]    dst_q, dst_d;
  logic [MAX_OUT-1:0]     free_q, free_d;
  logic [SLOT_W:0]        wptr_q, wptr_d;
  logic [SLOT_W:0]        rptr_q, rptr_d;

  logic [31:0]            idx_q  [MAX_OUT];
  logic [CACHE_WIDTH-1:0] data_q [MAX_OUT];
  logic [SLOT_W-1:0]      fifo_q [MAX_OUT];

  logic              in_run, start_acc;
  logic              alloc_ok;
  logic [SLOT_W-1:0] alloc_slot, wr_slot, rsp_slot;
  logic              fifo_empty, fifo_full;
  logic              rd_fire, wr_fire, rd_acc, w0_acc, w1_acc;
  logic              unused_inputs;

  assign in_run    = (state_q == RUN);
  assign start_acc = start && !in_run;

  // Lowest-numbered free slot wins.
  always_comb begin
    alloc_ok   = 1'b0;
    alloc_slot = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (free_q[i]) begin
        alloc_ok   = 1'b1;
        alloc_slot = SLOT_W'(i);
      end
    end
  end

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[SLOT_W] != rptr_q[SLOT_W]) &&
                      (wptr_q[SLOT_W-1:0] == rptr_q[SLOT_W-1:0]);
  assign wr_slot    = fifo_q[rptr_q[SLOT_W-1:0]];
  assign rsp_slot   = rd_rsp_mdata[SLOT_W-1:0];

  assign rd_fire = in_run && (rd_issued_q < num_q) && alloc_ok && !rd_req_almostfull;
  assign wr_fire = in_run && !fifo_empty && !wr_req_almostfull;
  assign rd_acc  = in_run && rd_rsp_valid && !fifo_full;
  assign w0_acc  = in_run && wr_rsp0_valid;
  assign w1_acc  = in_run && wr_rsp1_valid;

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rd_issued_d = rd_issued_q;
    wr_done_d   = wr_done_q;
    free_d      = free_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    if (start_acc) begin
      num_d       = afu_context[31:0];
      src_d       = afu_context[32 +: ADDR_LMT];
      dst_d       = afu_context[64 +: ADDR_LMT];
      rd_issued_d = '0;
      wr_done_d   = '0;
      free_d      = '1;
      wptr_d      = '0;
      rptr_d      = '0;
      state_d     = (afu_context[31:0] == 32'd0) ? DONE : RUN;
    end else if (in_run) begin
      if (rd_fire) begin
        free_d[alloc_slot] = 1'b0;
        rd_issued_d        = rd_issued_q + 32'd1;
      end
      if (w0_acc) free_d[wr_rsp0_mdata[SLOT_W-1:0]] = 1'b1;
      if (w1_acc) free_d[wr_rsp1_mdata[SLOT_W-1:0]] = 1'b1;
      wr_done_d = wr_done_q + 32'(w0_acc) + 32'(w1_acc);
      if (rd_acc)  wptr_d = wptr_q + (SLOT_W + 1)'(1);
      if (wr_fire) rptr_d = rptr_q + (SLOT_W + 1)'(1);
      if (wr_done_d == num_q) state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      num_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      rd_issued_q <= '0;
      wr_done_q   <= '0;
      free_q      <= '1;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rd_issued_q <= rd_issued_d;
      wr_done_q   <= wr_done_d;
      free_q      <= free_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  // Slot payload needs no reset: it is only read after being written in the current job.
  always_ff @(posedge clk) begin
    if (rd_fire) idx_q[alloc_slot] <= rd_issued_q;
    if (rd_acc) begin
      data_q[rsp_slot]               <= rd_rsp_data;
      fifo_q[wptr_q[SLOT_W-1:0]]     <= rsp_slot;
    end
  end

  assign rd_req_en   = rd_fire;
  assign rd_req_addr = src_q + ADDR_LMT'(rd_issued_q);
  assign wr_req_en   = wr_fire;
  assign wr_req_addr = dst_q + ADDR_LMT'(idx_q[wr_slot]);
  assign wr_req_data = data_q[wr_slot];
  assign done        = (state_q == DONE);

  always_comb begin
    rd_req_mdata               = '0;
    rd_req_mdata[SLOT_W-1:0]   = alloc_slot;
    wr_req_mdata               = '0;
    wr_req_mdata[SLOT_W-1:0]   = wr_slot;
  end

`ifdef AFU_COPY_MO_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  function automatic logic [31:0] fold32(input logic [CACHE_WIDTH-1:0] d);
    logic [31:0] acc;
    acc = '0;
    for (int w = 0; w < CACHE_WIDTH / 32; w++) acc = acc ^ d[w*32 +: 32];
    return acc;
  endfunction

  always_comb begin
    checksum_d = checksum_q;
    if (start_acc)   checksum_d = '0;
    else if (rd_acc) checksum_d = checksum_q ^ fold32(rd_rsp_data);
  end

  always_ff @(posedge clk) begin
    if (reset) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'd0;
`endif

  // Descriptor bits above the address fields and tag bits above the slot number carry nothing.
  assign unused_inputs = ^{afu_context, rd_rsp_mdata, wr_rsp0_mdata, wr_rsp1_mdata};

endmodule

// File: tb/tb_afu_copy_mo.sv
// Directed bench for afu_copy_mo: expected requests are queued as stimulus is issued and a
// negedge monitor pops and compares every rd/wr request the DUT presents.
module tb_afu_copy_mo;

  localparam int AL   = 20;
  localparam int MD   = 14;
  localparam int CW   = 512;
  localparam int MO   = 8;
  localparam int RD_W = AL + MD;
  localparam int WR_W = AL + MD + CW;

`ifdef AFU_COPY_MO_CHECKSUM_EN
  localparam logic [31:0] CK_A5 = 32'hA5A5A5A5;
`else
  localparam logic [31:0] CK_A5 = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AL-1:0] rd_req_addr, wr_req_addr;
  logic [MD-1:0] rd_req_mdata, wr_req_mdata;
  logic          rd_req_en, wr_req_en, done;
  logic          rd_req_almostfull = 1'b0, wr_req_almostfull = 1'b0;
  logic          rd_rsp_valid = 1'b0;
  logic [MD-1:0] rd_rsp_mdata = '0;
  logic [CW-1:0] rd_rsp_data = '0, wr_req_data;
  logic          wr_rsp0_valid = 1'b0, wr_rsp1_valid = 1'b0;
  logic [MD-1:0] wr_rsp0_mdata = '0, wr_rsp1_mdata = '0;
  logic          start = 1'b0;
  logic [511:0]  afu_context = '0;
  logic [31:0]   checksum;

  logic [RD_W-1:0] rd_exp_q[$];
  logic [WR_W-1:0] wr_exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int rd_seen  = 0;
  int wr_seen  = 0;

  always #5 clk = ~clk;

  afu_copy_mo #(.ADDR_LMT(AL), .MDATA(MD), .CACHE_WIDTH(CW), .MAX_OUT(MO)) dut (
    .clk(clk), .reset(reset),
    .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
    .rd_req_almostfull(rd_req_almostfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
    .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
    .wr_req_en(wr_req_en), .wr_req_almostfull(wr_req_almostfull),
    .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp1_valid(wr_rsp1_valid),
    .wr_rsp0_mdata(wr_rsp0_mdata), .wr_rsp1_mdata(wr_rsp1_mdata),
    .start(start), .done(done), .afu_context(afu_context), .checksum(checksum)
  );

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [RD_W-1:0] re;
    logic [WR_W-1:0] we;
    if (rd_req_en) begin
      rd_seen++;
      n_checks++;
      if (rd_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_req: got addr=%h tag=%0d, required no request", rd_req_addr, rd_req_mdata);
      end else begin
        re = rd_exp_q.pop_front();
        if ({rd_req_addr, rd_req_mdata} !== re) begin
          n_fail++;
          $display("FAIL rd_req: got addr=%h tag=%0d, required addr=%h tag=%0d",
                   rd_req_addr, rd_req_mdata, re[RD_W-1:MD], re[MD-1:0]);
        end
      end
    end
    if (wr_req_en) begin
      wr_seen++;
      n_checks++;
      if (wr_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_req: got addr=%h tag=%0d, required no request", wr_req_addr, wr_req_mdata);
      end else begin
        we = wr_exp_q.pop_front();
        if ({wr_req_addr, wr_req_mdata, wr_req_data} !== we) begin
          n_fail++;
          $display("FAIL wr_req: got addr=%h tag=%0d data[63:0]=%h, required addr=%h tag=%0d data[63:0]=%h",
                   wr_req_addr, wr_req_mdata, wr_req_data[63:0],
                   we[WR_W-1:MD+CW], we[MD+CW-1:CW], we[63:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] line_data(input int pat, input int idx);
    logic [CW-1:0] d;
    d = '0;
    for (int w = 0; w < CW / 32; w++) begin
      case (pat)
        0:       d[w*32 +: 32] = 32'hD000_0000 + 32'(idx * 256 + w);
        1:       d[w*32 +: 32] = (w == 0) ? 32'hA5A5_A5A5 : 32'h0;
        default: d[w*32 +: 32] = 32'h0000_0001;
      endcase
    end
    return d;
  endfunction

  task automatic exp_rd(input int a, input int tag);
    rd_exp_q.push_back({AL'(a), MD'(tag)});
  endtask

  task automatic exp_wr(input int a, input int tag, input logic [CW-1:0] d);
    wr_exp_q.push_back({AL'(a), MD'(tag), d});
  endtask

  task automatic do_start(input int n, input int src, input int dst);
    afu_context = {416'b0, 32'(dst), 32'(src), 32'(n)};
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rd_rsp(input int tag, input logic [CW-1:0] d);
    rd_rsp_valid = 1'b1;
    rd_rsp_mdata = MD'(tag);
    rd_rsp_data  = d;
    tick();
    rd_rsp_valid = 1'b0;
  endtask

  task automatic wr_rsp(input logic v0, input int t0, input logic v1, input int t1);
    wr_rsp0_valid = v0;
    wr_rsp0_mdata = MD'(t0);
    wr_rsp1_valid = v1;
    wr_rsp1_mdata = MD'(t1);
    tick();
    wr_rsp0_valid = 1'b0;
    wr_rsp1_valid = 1'b0;
  endtask

  // In-order job of n <= MAX_OUT lines: tag i carries line i.
  task automatic run_job(input int n, input int src, input int dst, input int pat);
    for (int i = 0; i < n; i++) exp_rd(src + i, i);
    do_start(n, src, dst);
    repeat (n + 1) tick();
    for (int i = 0; i < n; i++) begin
      exp_wr(dst + i, i, line_data(pat, i));
      rd_rsp(i, line_data(pat, i));
    end
    repeat (3) tick();
    for (int i = 0; i < n; i++) begin
      check("done_before_last_wr_rsp", done, 0);
      if (i % 2 == 1) wr_rsp(1'b0, 0, 1'b1, i);
      else            wr_rsp(1'b1, i, 1'b0, 0);
    end
    check("done_after_last_wr_rsp", done, 1);
    check("rd_exp_empty", rd_exp_q.size(), 0);
    check("wr_exp_empty", wr_exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rd0, wr0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_done", done, 0);
    check("reset_rd_en", rd_req_en, 0);
    check("reset_wr_en", wr_req_en, 0);
    check("reset_checksum", checksum, 0);

    // Basic in-order copy of 4 lines.
    run_job(4, 'h100, 'h200, 0);

    // Out-of-order read responses 3,1,0,2 with both backpressure inputs exercised.
    for (int i = 0; i < 4; i++) exp_rd('h300 + i, i);
    rd_req_almostfull = 1'b1;
    do_start(4, 'h300, 'h400);
    check("rd_almostfull_gate", rd_req_en, 0);
    rd_req_almostfull = 1'b0;
    repeat (5) tick();
    wr_req_almostfull = 1'b1;
    exp_wr('h403, 3, line_data(0, 3)); rd_rsp(3, line_data(0, 3));
    exp_wr('h401, 1, line_data(0, 1)); rd_rsp(1, line_data(0, 1));
    exp_wr('h400, 0, line_data(0, 0)); rd_rsp(0, line_data(0, 0));
    exp_wr('h402, 2, line_data(0, 2)); rd_rsp(2, line_data(0, 2));
    tick();
    check("wr_almostfull_gate", wr_req_en, 0);
    wr_req_almostfull = 1'b0;
    repeat (5) tick();
    check("ooo_writes_issued", wr_exp_q.size(), 0);
    wr_rsp(1'b1, 3, 1'b1, 1);
    check("dual_wr_rsp_not_done", done, 0);
    wr_rsp(1'b1, 0, 1'b1, 2);
    check("dual_wr_rsp_done", done, 1);

    // Outstanding limit: 16 lines, responses withheld.
    rd0 = rd_seen;
    for (int i = 0; i < MO; i++) exp_rd('h1000 + i, i);
    do_start(16, 'h1000, 'h2000);
    repeat (12) tick();
    check("max_out_reads", rd_seen - rd0, MO);
    check("max_out_stall", rd_req_en, 0);
    exp_wr('h2000, 0, line_data(0, 0));
    rd_rsp(0, line_data(0, 0));
    repeat (3) tick();
    exp_rd('h1008, 0);
    wr_rsp(1'b0, 0, 1'b1, 0);
    repeat (4) tick();
    check("one_more_read", rd_seen - rd0, MO + 1);
    check("max_out_not_done", done, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abandon_done", done, 0);

    // Reset with 3 reads outstanding; late responses must be ignored.
    for (int i = 0; i < 3; i++) exp_rd('h500 + i, i);
    do_start(3, 'h500, 'h600);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_rd_en", rd_req_en, 0);
    check("mid_reset_wr_en", wr_req_en, 0);
    check("mid_reset_done", done, 0);
    rd0 = rd_seen;
    wr0 = wr_seen;
    for (int i = 0; i < 3; i++) rd_rsp(i, line_data(0, i));
    wr_rsp(1'b1, 0, 1'b1, 1);
    repeat (4) tick();
    check("late_rsp_no_writes", wr_seen - wr0, 0);
    check("late_rsp_no_reads", rd_seen - rd0, 0);
    check("late_rsp_done", done, 0);

    // Zero-length job.
    rd0 = rd_seen;
    do_start(0, 'h40, 'h80);
    check("zero_len_done", done, 1);
    repeat (3) tick();
    check("zero_len_no_reads", rd_seen - rd0, 0);

    // Checksum jobs; the second also wraps the address space.
    run_job(1, 'h700, 'h780, 1);
    check("checksum_a5", checksum, CK_A5);
    run_job(2, 'hFFFFF, 'hFFFFF, 2);
    check("checksum_ones_cleared", checksum, 0);

    check("final_rd_exp_empty", rd_exp_q.size(), 0);
    check("final_wr_exp_empty", wr_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
